// File: rtl/sat_frame_streamer_if.sv
// Handshake bundle between the saturation stage, the frame streamer and the
// byte-wide downstream writer.
interface sat_frame_streamer_if #(
  parameter int LANES = 10,
  parameter int W     = 8,
  parameter int IDXW  = 4
);
  logic                 sat_rdy;
  logic [LANES*W-1:0]   sat_data;
  logic                 received;
  logic [W-1:0]         m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic [IDXW-1:0]      lane_idx;

  modport slave (
    input  sat_rdy, sat_data, m_ready,
    output received, m_data, m_valid, m_last, lane_idx
  );

  modport master (
    output sat_rdy, sat_data, m_ready,
    input  received, m_data, m_valid, m_last, lane_idx
  );
endinterface

// File: rtl/sat_frame_streamer.sv
// Captures one saturated frame, acknowledges it, then streams it one lane per
// valid/ready transfer while reporting how many lanes were clamped to 0x7F.
module sat_frame_streamer #(
  parameter int LANES = 10,
  parameter int W     = 8,
  parameter int IDXW  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sat_frame_streamer_if.slave  bus,
  output logic [IDXW-1:0]      frame_sat_cnt,
  output logic                 frame_done,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACK, STREAM} state_t;

  localparam logic [W-1:0]    CLAMP    = W'(8'h7F);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

  state_t          state, state_n;
  logic [W-1:0]    frame_buf [LANES];
  logic [W-1:0]    lane_in   [LANES];
  logic [IDXW-1:0] clamp_cnt;

  logic            capture;
  logic            received_n, m_valid_n, m_last_n, frame_done_n;
  logic [W-1:0]    m_data_n;
  logic [IDXW-1:0] lane_idx_n, frame_sat_cnt_n;

  // Lane i sits at bits [W*i +: W] with bit W*i as its MSB, so bits reverse.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned b = 0; b < W; b++) begin
        lane_in[i][W-1-b] = bus.sat_data[W*i+b];
      end
    end
  end

  always_comb begin
    clamp_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_in[i] == CLAMP) clamp_cnt = clamp_cnt + IDXW'(1);
    end
  end

  always_comb begin
    state_n         = state;
    capture         = 1'b0;
    received_n      = bus.received;
    m_valid_n       = bus.m_valid;
    m_last_n        = bus.m_last;
    m_data_n        = bus.m_data;
    lane_idx_n      = bus.lane_idx;
    frame_sat_cnt_n = frame_sat_cnt;
    frame_done_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.sat_rdy) begin
          capture         = 1'b1;
          frame_sat_cnt_n = clamp_cnt;
          received_n      = 1'b1;
          state_n         = ACK;
        end
      end
      ACK: begin
        if (!bus.sat_rdy) begin
          received_n = 1'b0;
          m_valid_n  = 1'b1;
          lane_idx_n = '0;
          m_data_n   = frame_buf[0];
          m_last_n   = (LANES == 1);
          state_n    = STREAM;
        end
      end
      STREAM: begin
        if (bus.m_ready) begin
          if (bus.lane_idx == LAST_IDX) begin
            m_valid_n    = 1'b0;
            m_last_n     = 1'b0;
            lane_idx_n   = '0;
            frame_done_n = 1'b1;
            state_n      = IDLE;
          end else begin
            lane_idx_n = bus.lane_idx + IDXW'(1);
            m_data_n   = frame_buf[lane_idx_n];
            m_last_n   = (lane_idx_n == LAST_IDX);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.received  <= 1'b0;
      bus.m_valid   <= 1'b0;
      bus.m_last    <= 1'b0;
      bus.m_data    <= '0;
      bus.lane_idx  <= '0;
      frame_sat_cnt <= '0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) frame_buf[i] <= '0;
    end else begin
      state         <= state_n;
      bus.received  <= received_n;
      bus.m_valid   <= m_valid_n;
      bus.m_last    <= m_last_n;
      bus.m_data    <= m_data_n;
      bus.lane_idx  <= lane_idx_n;
      frame_sat_cnt <= frame_sat_cnt_n;
      frame_done    <= frame_done_n;
      busy          <= (state_n != IDLE);
      if (capture) begin
        for (int unsigned i = 0; i < LANES; i++) frame_buf[i] <= lane_in[i];
      end
    end
  end

endmodule
